// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt capture stage feeding the 8x3 priority encoder.
package irq_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  // Decode an encoder index back into a one-hot line select.
  function automatic irq_vec_t id_to_onehot(input logic [ID_W-1:0] id);
    return irq_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/irq_latch_8_sync_ff.sv
// Single-bit synchronizer chain for one asynchronous request line.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_latch_8.sv
// Eight-line interrupt capture: synchronize, detect edge/level events, hold pending until acked.
module irq_latch_8
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       edge_mode,
  input  logic       ack,
  input  logic [2:0] ack_id,
  input  logic       ovr_clr,
  output logic [7:0] data_out,
  output logic       enable_out,
  output logic [7:0] overrun
);

  irq_vec_t sync_q;
  irq_vec_t prev_q;
  irq_vec_t pending_q;
  irq_vec_t overrun_q;
  irq_vec_t ev;
  irq_vec_t clr;
  irq_vec_t ovr_set;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    sync_ff #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq_in[i]),
      .q    (sync_q[i])
    );
  end

  // A fresh event on a bit that is still pending (and not being cleared now) is a lost event.
  always_comb begin
    ev      = edge_mode ? (sync_q & ~prev_q) : sync_q;
    clr     = ack ? id_to_onehot(ack_id) : '0;
    ovr_set = edge_mode ? (ev & pending_q & ~clr) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      prev_q    <= sync_q;
      pending_q <= ev | (pending_q & ~clr);
      overrun_q <= ovr_set | (overrun_q & ~{NUM_IRQ{ovr_clr}});
    end
  end

  assign data_out   = pending_q & ~mask;
  assign enable_out = |data_out;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_irq_latch_8.sv
// Scoreboard bench for irq_latch_8: a cycle model queues expected outputs, popped after each edge.
module tb_irq_latch_8;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       en;
    logic [7:0] ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       edge_mode;
  logic       ack;
  logic [2:0] ack_id;
  logic       ovr_clr;
  logic [7:0] data_out;
  logic       enable_out;
  logic [7:0] overrun;

  logic [7:0] m_stage [SYNC];
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic [7:0] m_ovr;
  exp_t       sb_q [$];

  int vec_count  = 0;
  int miss_count = 0;

  irq_latch_8 #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .edge_mode (edge_mode),
    .ack       (ack),
    .ack_id    (ack_id),
    .ovr_clr   (ovr_clr),
    .data_out  (data_out),
    .enable_out(enable_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SYNC; s++) m_stage[s] = '0;
    m_prev = '0;
    m_pend = '0;
    m_ovr  = '0;
  endtask

  // Advance the model by one edge using the inputs currently driven, then let the DUT take the
  // same edge and compare against the queued prediction.
  task automatic apply_stimulus(input int cycles);
    logic [7:0] sync, ev, clr, ovr_set;
    exp_t e, got;
    for (int c = 0; c < cycles; c++) begin
      if (!rst_n) begin
        model_reset();
      end else begin
        sync    = m_stage[SYNC-1];
        ev      = edge_mode ? (sync & ~m_prev) : sync;
        clr     = ack ? (8'd1 << ack_id) : 8'd0;
        ovr_set = edge_mode ? (ev & m_pend & ~clr) : 8'd0;
        m_ovr   = ovr_set | (ovr_clr ? 8'd0 : m_ovr);
        m_pend  = ev | (m_pend & ~clr);
        m_prev  = sync;
        for (int s = SYNC - 1; s > 0; s--) m_stage[s] = m_stage[s-1];
        m_stage[0] = irq_in;
      end
      e.data = m_pend & ~mask;
      e.en   = |(m_pend & ~mask);
      e.ovr  = m_ovr;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check_output("sb_data", data_out, got.data);
      check_output("sb_en", {7'd0, enable_out}, {7'd0, got.en});
      check_output("sb_ovr", overrun, got.ovr);
    end
  endtask

  task automatic ack_line(input logic [2:0] id);
    ack    = 1'b1;
    ack_id = id;
    apply_stimulus(1);
    ack    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, data_out, 8'h00);
    check_output({tag, "_en"}, {7'd0, enable_out}, 8'h00);
    check_output({tag, "_ovr"}, overrun, 8'h00);
  endtask

  initial begin
    #20000;
    miss_count++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    irq_in    = 8'hFF;
    mask      = 8'h00;
    edge_mode = 1'b1;
    ack       = 1'b0;
    ack_id    = 3'd0;
    ovr_clr   = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    apply_stimulus(2);
    rst_n = 1'b1;

    // All lines high at release: visible after SYNC+1 edges, not before.
    apply_stimulus(SYNC);
    check_output("release_early", data_out, 8'h00);
    apply_stimulus(1);
    check_output("release_all", data_out, 8'hFF);
    irq_in = 8'h00;
    apply_stimulus(3);
    for (int i = 0; i < 8; i++) ack_line(3'(i));
    check_output("drain", data_out, 8'h00);

    // Edge capture on bit 5 and ack.
    irq_in = 8'h20;
    apply_stimulus(3);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("edge5_held", data_out, 8'h20);
    check_output("edge5_en", {7'd0, enable_out}, 8'h01);
    ack_line(3'd5);
    check_output("edge5_acked", data_out, 8'h00);

    // Bit 2: new edge lands on the same edge as its ack.
    irq_in = 8'h04;
    apply_stimulus(2);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("b2_first", data_out, 8'h04);
    irq_in = 8'h04;
    apply_stimulus(SYNC);
    ack_line(3'd2);
    check_output("b2_setwins", data_out, 8'h04);
    check_output("b2_no_ovr", overrun, 8'h00);
    irq_in = 8'h00;
    apply_stimulus(3);
    ack_line(3'd2);

    // Bit 3: second edge while still pending.
    irq_in = 8'h08;
    apply_stimulus(2);
    irq_in = 8'h00;
    apply_stimulus(2);
    irq_in = 8'h08;
    apply_stimulus(2);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("ovr_set", overrun, 8'h08);
    ovr_clr = 1'b1;
    apply_stimulus(1);
    ovr_clr = 1'b0;
    check_output("ovr_clr", overrun, 8'h00);
    ack_line(3'd3);

    // Masked bit 7 latches but stays hidden until unmasked.
    mask   = 8'h80;
    irq_in = 8'h80;
    apply_stimulus(2);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("mask_data", data_out, 8'h00);
    check_output("mask_en", {7'd0, enable_out}, 8'h00);
    mask = 8'h00;
    #1;
    check_output("unmask_data", data_out, 8'h80);
    check_output("unmask_en", {7'd0, enable_out}, 8'h01);
    ack_line(3'd7);

    // Level mode: ack cannot stick while the line is high.
    edge_mode = 1'b0;
    irq_in    = 8'h02;
    apply_stimulus(4);
    ack_line(3'd1);
    apply_stimulus(1);
    check_output("level_hold", data_out, 8'h02);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("level_stays", data_out, 8'h02);
    ack_line(3'd1);
    check_output("level_clr", data_out, 8'h00);
    edge_mode = 1'b1;
    apply_stimulus(1);

    // Asynchronous reset mid-ack with bits 6 and 0 pending.
    irq_in = 8'h41;
    apply_stimulus(2);
    irq_in = 8'h00;
    apply_stimulus(3);
    check_output("pre_reset", data_out, 8'h41);
    ack    = 1'b1;
    ack_id = 3'd6;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    ack = 1'b0;
    apply_stimulus(1);
    rst_n = 1'b1;
    apply_stimulus(4);
    check_all_zero("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/irq_latch_8.md
# irq_latch_8

Eight-line interrupt capture stage that sits directly upstream of the 8x3 priority encoder. It synchronizes asynchronous request lines, detects events (rising edge or level), and holds them in a pending register until acknowledged. It presents the masked pending vector and an enable to the encoder. The encoder's 3-bit result returns as the acknowledge ID, closing the loop.

## Interface
- SYNC_STAGES, 2, synchronizer depth per request line; legal values 2 or 3.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock, no other clock domains.
- irq_in  input  8  asynchronous request lines; bit 7 is highest priority downstream.
- mask  input  8  synchronous; 1 = line hidden from data_out/enable_out (still latched).
- edge_mode  input  1  1 = latch on rising edge; 0 = level-sensitive.
- ack  input  1  one-cycle acknowledge strobe.
- ack_id  input  3  index of pending bit cleared by ack; normally the encoder's data_out.
- ovr_clr  input  1  clears all overrun flags.
- data_out  output  8  pending & ~mask; drives encoder data_in.
- enable_out  output  1  OR-reduce of data_out; drives encoder enable.
- overrun  output  8  sticky per-line lost-event flags.

## Operation
- Per bit i: SYNC_STAGES flops → sync[i]; prev[i] = sync[i] delayed one cycle.
- Event: edge_mode=1 → ev[i] = sync[i] & ~prev[i]; edge_mode=0 → ev[i] = sync[i].
- Clear: clr[i] = ack & (ack_id == i).
- Pending update: pending[i] <= ev[i] | (pending[i] & ~clr[i]). Set wins over clear on the same bit in the same cycle.
- Overrun: set overrun[i] when edge_mode=1 & ev[i] & pending[i] & ~clr[i]. Never set in level mode. Cleared by ovr_clr; a new set in the same cycle wins over ovr_clr.
- Ack of a non-pending or masked bit: no effect, no error.
- Mask affects only the outputs. A masked bit keeps latching and is visible on data_out once unmasked.
- Level mode: the bit stays pending while the line is high, so ack has no lasting effect. The bit clears on the first ack after the line drops.
- edge_mode change: takes effect from the next clock. Existing pending bits are untouched.
- Reset (asserted at any time, including mid-ack): sync, prev, pending and overrun all go to 0 immediately. data_out=0, enable_out=0, overrun=0 while rst_n=0 and after release.

## Timing
- Latency: irq_in high sampled at edge N → pending set at edge N+SYNC_STAGES → data_out/enable_out valid in that cycle. Outputs are combinational from pending and mask.
- data_out/enable_out change the same cycle mask changes (combinational path).
- ack at edge M clears the bit at edge M; data_out drops after edge M.
- Downstream loop: encoder output feeds ack_id combinationally. The controller must hold ack for a single cycle per serviced interrupt.
- Edge mode: pulses shorter than one clk period may be missed. The minimum guaranteed pulse is 2 clk periods high and 2 low.
- No output depends combinationally on irq_in.

## Structure
- Shared package irq_pkg: NUM_IRQ=8, ID_W=3, and the type for the 8-bit irq vector.
- Sub-module sync_ff: parameterized single-bit SYNC_STAGES flop chain with async active-low reset. Instantiated 8 times via generate.
- Top: edge detect, pending/overrun registers, and output logic.

## Test plan
- Reset: rst_n=0 with irq_in=8'hFF → data_out=0, enable_out=0, overrun=0. Release, edge_mode=1 → data_out=8'hFF after SYNC_STAGES+1 edges.
- Edge capture/ack: pulse irq_in[5] for 3 cycles, mask=0 → data_out=8'h20 held after pulse ends. ack=1, ack_id=5 → data_out=8'h00 next cycle.
- Same-cycle set/clear: a new edge on bit 2 coincides with ack of bit 2 → bit 2 remains pending; overrun[2]=0.
- Overrun: bit 3 pending with no ack, second rising edge on irq_in[3] → overrun=8'h08. ovr_clr=1 → overrun=0.
- Mask: irq_in[7] edge with mask=8'h80 → data_out=0, enable_out=0. Set mask=0 → data_out=8'h80 in the same cycle.
- Level mode: edge_mode=0, irq_in[1] held high, ack bit 1 → data_out stays 8'h02. Drop the line, ack again → data_out=0.
- Mid-operation reset: assert rst_n=0 for one cycle while data_out=8'h41 → all outputs 0 immediately; no re-capture until new events arrive.
